// File: rtl/frogger_pkg.sv
// rtl/frogger_pkg.sv - shared game state encoding and active-low 7-segment patterns {g,f,e,d,c,b,a}
package frogger_pkg;

    typedef enum logic [1:0] {
        ST_PLAY      = 2'd0,
        ST_HOLD      = 2'd1,
        ST_GAME_OVER = 2'd2
    } game_state_e;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    function automatic logic [6:0] seg_of(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seven_seg_decode.sv
// rtl/seven_seg_decode.sv - 4-bit digit to active-low 7-segment pattern, values above 9 blank
module seven_seg_decode
    import frogger_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    assign seg = seg_of(digit);

endmodule

// File: rtl/game_state_ctrl.sv
// rtl/game_state_ctrl.sv - round/level/lives FSM driving round reset and digit displays
// Optional lives tracking and GAME_OVER state enabled by defining LIVES_EN.
module game_state_ctrl
    import frogger_pkg::*;
#(
    parameter int MAX_LEVEL   = 9,
    parameter int START_LIVES = 3,
    parameter int HOLD_CYCLES = 12500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       win_collision,
    input  logic       death_collision,
    input  logic       restart_req,
    output logic       round_reset,
    output logic [3:0] current_level,
    output logic [1:0] lives,
    output logic       game_over,
    output logic       level_wrap,
    output logic [6:0] o_Segment1,
    output logic [6:0] o_Segment2
);

    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYCLES - 1);
    localparam logic [3:0]    LEVEL_MAX  = 4'(MAX_LEVEL);
    localparam logic [1:0]    LIVES_INIT = 2'(START_LIVES);
`ifdef LIVES_EN
    localparam logic [6:0]    SEG1_INIT  = seg_of({2'b00, LIVES_INIT});
`else
    localparam logic [6:0]    SEG1_INIT  = SEG_BLANK;
`endif

    game_state_e   state_q, state_d;
    logic [3:0]    level_q, level_d;
    logic [1:0]    lives_q, lives_d;
    logic [CW-1:0] hold_cnt_q, hold_cnt_d;
    logic          round_reset_q, round_reset_d;
    logic          game_over_q, game_over_d;
    logic          level_wrap_q, level_wrap_d;
    logic [6:0]    seg1_q, seg1_d;
    logic [6:0]    seg2_q, seg2_d;
    logic          win_sync_q, win_sync_d, win_prev_q, win_prev_d;
    logic          death_sync_q, death_sync_d, death_prev_q, death_prev_d;
    logic          win_rise, death_rise;
    logic [3:0]    lives_digit;
    logic [6:0]    lives_seg, level_seg;

    // Edge detectors run in every state so a collision held through HOLD never re-fires.
    always_comb begin
        win_sync_d   = win_collision;
        win_prev_d   = win_sync_q;
        death_sync_d = death_collision;
        death_prev_d = death_sync_q;
        win_rise     = win_sync_q & ~win_prev_q;
        death_rise   = death_sync_q & ~death_prev_q;
    end

    always_comb begin
        state_d      = state_q;
        level_d      = level_q;
        lives_d      = lives_q;
        hold_cnt_d   = hold_cnt_q;
        level_wrap_d = 1'b0;
        case (state_q)
            ST_PLAY: begin
                hold_cnt_d = '0;
                if (win_rise) begin
                    if (level_q == LEVEL_MAX) begin
                        level_d      = 4'd0;
                        level_wrap_d = 1'b1;
                    end else begin
                        level_d = level_q + 4'd1;
                    end
                    state_d = ST_HOLD;
                end else if (death_rise) begin
`ifdef LIVES_EN
                    lives_d = lives_q - 2'd1;
                    state_d = (lives_q == 2'd1) ? ST_GAME_OVER : ST_HOLD;
`else
                    state_d = ST_HOLD;
`endif
                end else if (restart_req) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    hold_cnt_d = '0;
                    state_d    = ST_PLAY;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            ST_GAME_OVER: begin
                hold_cnt_d = '0;
                if (restart_req) begin
                    level_d = 4'd0;
                    lives_d = LIVES_INIT;
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d    = ST_PLAY;
                hold_cnt_d = '0;
            end
        endcase
    end

`ifdef LIVES_EN
    assign lives_digit = {2'b00, lives_d};
`else
    assign lives_digit = 4'hF;
`endif

    seven_seg_decode u_dec_lives (
        .digit (lives_digit),
        .seg   (lives_seg)
    );

    seven_seg_decode u_dec_level (
        .digit (level_d),
        .seg   (level_seg)
    );

    // Outputs are derived from next-state values so they line up with the registered state.
    always_comb begin
        round_reset_d = (state_d != ST_PLAY);
`ifdef LIVES_EN
        game_over_d   = (state_d == ST_GAME_OVER);
`else
        game_over_d   = 1'b0;
`endif
        seg1_d        = (state_d == ST_GAME_OVER) ? SEG_DASH : lives_seg;
        seg2_d        = (state_d == ST_GAME_OVER) ? SEG_DASH : level_seg;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_PLAY;
            level_q       <= 4'd0;
            lives_q       <= LIVES_INIT;
            hold_cnt_q    <= '0;
            round_reset_q <= 1'b0;
            game_over_q   <= 1'b0;
            level_wrap_q  <= 1'b0;
            seg1_q        <= SEG1_INIT;
            seg2_q        <= seg_of(4'd0);
            win_sync_q    <= 1'b0;
            win_prev_q    <= 1'b0;
            death_sync_q  <= 1'b0;
            death_prev_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            level_q       <= level_d;
            lives_q       <= lives_d;
            hold_cnt_q    <= hold_cnt_d;
            round_reset_q <= round_reset_d;
            game_over_q   <= game_over_d;
            level_wrap_q  <= level_wrap_d;
            seg1_q        <= seg1_d;
            seg2_q        <= seg2_d;
            win_sync_q    <= win_sync_d;
            win_prev_q    <= win_prev_d;
            death_sync_q  <= death_sync_d;
            death_prev_q  <= death_prev_d;
        end
    end

    assign round_reset   = round_reset_q;
    assign current_level = level_q;
    assign lives         = lives_q;
    assign game_over     = game_over_q;
    assign level_wrap    = level_wrap_q;
    assign o_Segment1    = seg1_q;
    assign o_Segment2    = seg2_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
// tb/tb_game_state_ctrl.sv - table-driven directed bench for game_state_ctrl (HOLD_CYCLES=4)
module tb_game_state_ctrl;

`ifdef LIVES_EN
    localparam bit LE = 1'b1;
`else
    localparam bit LE = 1'b0;
`endif

    localparam logic [6:0] BLANK = 7'b1111111;
    localparam logic [6:0] DASH  = 7'b0111111;

    logic       clk = 1'b0;
    logic       reset, win_collision, death_collision, restart_req;
    logic       round_reset, game_over, level_wrap;
    logic [3:0] current_level;
    logic [1:0] lives;
    logic [6:0] o_Segment1, o_Segment2;

    int checks = 0;
    int errors = 0;

    game_state_ctrl #(.MAX_LEVEL(9), .START_LIVES(3), .HOLD_CYCLES(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .win_collision   (win_collision),
        .death_collision (death_collision),
        .restart_req     (restart_req),
        .round_reset     (round_reset),
        .current_level   (current_level),
        .lives           (lives),
        .game_over       (game_over),
        .level_wrap      (level_wrap),
        .o_Segment1      (o_Segment1),
        .o_Segment2      (o_Segment2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        win;
        logic        death;
        logic        rst_req;
        int          cycles;
        logic [22:0] exp;
        string       name;
    } vec_t;

    vec_t vq[$];

    function automatic logic [6:0] dig(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return BLANK;
        endcase
    endfunction

    function automatic logic [6:0] s1(input int lv);
        return LE ? dig(lv) : BLANK;
    endfunction

    // {level, lives, round_reset, game_over, level_wrap, seg1, seg2}
    function automatic logic [22:0] e(input int lvl, input int lv, input bit rr,
                                      input bit go, input bit wr,
                                      input logic [6:0] g1, input logic [6:0] g2);
        return {4'(lvl), 2'(lv), rr, go, wr, g1, g2};
    endfunction

    function automatic logic [22:0] play(input int lvl, input int lv);
        return e(lvl, lv, 1'b0, 1'b0, 1'b0, s1(lv), dig(lvl));
    endfunction

    task automatic add(input logic w, input logic d, input logic r, input int n,
                       input logic [22:0] x, input string nm);
        vec_t v;
        v.win = w; v.death = d; v.rst_req = r; v.cycles = n; v.exp = x; v.name = nm;
        vq.push_back(v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [22:0] x);
        logic [22:0] obs;
        obs = {current_level, lives, round_reset, game_over, level_wrap, o_Segment1, o_Segment2};
        checks++;
        if (obs !== x) begin
            errors++;
            $display("FAIL %s: got lvl=%0d lives=%0d rr=%b go=%b wrap=%b seg1=%b seg2=%b, want lvl=%0d lives=%0d rr=%b go=%b wrap=%b seg1=%b seg2=%b",
                     nm, obs[22:19], obs[18:17], obs[16], obs[15], obs[14], obs[13:7], obs[6:0],
                     x[22:19], x[18:17], x[16], x[15], x[14], x[13:7], x[6:0]);
        end
    endtask

    task automatic chk_int(input string nm, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", nm, got, want);
        end
    endtask

    initial begin
        int lvl_end;
        int rr_cnt;
        int wrap_cnt;
        int l2, l1;

        reset = 1'b1; win_collision = 1'b0; death_collision = 1'b0; restart_req = 1'b0;
        step(); step(); step();
        chk("reset_values", play(0, 3));
        reset = 1'b0;

        // Build the vector table
        add(0, 0, 0, 10, play(0, 3), "idle_after_reset");
        for (int i = 1; i <= 9; i++) begin
            add(1, 0, 0, 1, play(i - 1, 3), "win_pulse");
            add(0, 0, 0, 7, play(i, 3), "win_done");
        end
        add(1, 0, 0, 1, play(9, 3), "win10_pulse");
        add(0, 0, 0, 1, e(0, 3, 1'b1, 1'b0, 1'b1, s1(3), dig(0)), "wrap_pulse");
        add(0, 0, 0, 6, play(0, 3), "wrap_done");
        add(1, 1, 0, 1, play(0, 3), "win_death_pulse");
        add(0, 0, 0, 7, play(1, 3), "win_beats_death");
        l2 = LE ? 2 : 3;
        l1 = LE ? 1 : 3;
        add(0, 1, 0, 1, play(1, 3), "death1_pulse");
        add(0, 0, 0, 7, play(1, l2), "death1_done");
        add(0, 1, 0, 1, play(1, l2), "death2_pulse");
        add(0, 0, 0, 7, play(1, l1), "death2_done");
        add(0, 1, 0, 1, play(1, l1), "death3_pulse");
        if (LE) begin
            add(0, 0, 0, 7, e(1, 0, 1'b1, 1'b1, 1'b0, DASH, DASH), "game_over");
            add(0, 0, 0, 10, e(1, 0, 1'b1, 1'b1, 1'b0, DASH, DASH), "game_over_stays");
            add(0, 0, 1, 1, e(0, 3, 1'b1, 1'b0, 1'b0, s1(3), dig(0)), "restart_from_go");
            add(0, 0, 0, 6, play(0, 3), "restart_done");
        end else begin
            add(0, 0, 0, 7, play(1, 3), "death3_no_lives");
            add(0, 0, 0, 10, play(1, 3), "death3_stays_play");
        end
        lvl_end = LE ? 0 : 1;
        add(0, 0, 1, 1, e(lvl_end, 3, 1'b1, 1'b0, 1'b0, s1(3), dig(lvl_end)), "restart_in_play");
        add(0, 0, 0, 6, play(lvl_end, 3), "restart_in_play_done");

        foreach (vq[k]) begin
            win_collision   = vq[k].win;
            death_collision = vq[k].death;
            restart_req     = vq[k].rst_req;
            for (int c = 0; c < vq[k].cycles; c++) step();
            chk(vq[k].name, vq[k].exp);
        end
        win_collision = 1'b0; death_collision = 1'b0; restart_req = 1'b0;

        // Win held for 20 cycles: one level step, round_reset held exactly 4 cycles
        rr_cnt = 0;
        wrap_cnt = 0;
        win_collision = 1'b1;
        for (int c = 0; c < 20; c++) begin
            step();
            if (round_reset) rr_cnt++;
            if (level_wrap) wrap_cnt++;
        end
        win_collision = 1'b0;
        for (int c = 0; c < 8; c++) begin
            step();
            if (round_reset) rr_cnt++;
        end
        chk_int("held_win_rr_cycles", rr_cnt, 4);
        chk_int("held_win_no_wrap", wrap_cnt, 0);
        chk("held_win_level", play(lvl_end + 1, 3));

        // Reset asserted while hold_cnt is 2
        win_collision = 1'b1;
        step();
        win_collision = 1'b0;
        step();
        chk_int("hold_entered", int'(round_reset), 1);
        step();
        step();
        reset = 1'b1;
        step();
        chk("reset_mid_hold", play(0, 3));
        reset = 1'b0;
        for (int c = 0; c < 6; c++) step();
        chk("after_reset_idle", play(0, 3));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
